i2c_master_ctrl: RTL and testbench
==================================

Name: i2c_master_ctrl

Overview:
Single-byte I2C master sequencer that drives the bus toward the existing i2c slave.
- Accepts one command at a time: address, R/W, write data.
- Generates START, address phase, one data byte, ACK handling and STOP on SCL/SDA.
- Used as on-chip bus controller and as a synthesizable stimulus source replacing hand-timed SDA waveforms in slave benches.

Parameters:
- CLK_DIV, 25, clk cycles per SCL quarter-period (legal range 2..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command
- cmd_rw  in  1  0=write, 1=read
- cmd_addr  in  7  slave address
- cmd_wdata  in  8  write byte
- rd_data  out  8  byte read from slave
- rd_valid  out  1  one-cycle pulse, rd_data valid
- ack_err  out  1  slave NACKed (sticky until next accepted command)
- busy  out  1  transaction in progress
- SCL  out  1  bus clock (push-pull)
- sda_oe  out  1  1 = pull SDA low, 0 = release (open-drain)
- sda_in  in  1  sampled SDA
- scl_in  in  1  sampled SCL (stretch detect)

Behaviour:
- Reset (synchronous, takes effect at next edge even mid-transaction): SCL=1, sda_oe=0, busy=0, cmd_ready=1, rd_valid=0, ack_err=0, rd_data=0x00, FSM=IDLE, divider=0. No STOP is generated; bus is simply released.
- Handshake:
  - cmd_ready = ~busy.
  - Accept on cmd_valid & cmd_ready; cmd_* latched that cycle; busy=1 from next cycle.
  - cmd_valid while busy is ignored.
- Timing:
  - Divider emits a quarter tick every CLK_DIV clks. Each phase is 4 quarters q0..q3.
  - Bit phases: SCL=0 in q0,q1; SCL=1 in q2,q3. SDA changes only at q0 entry. SDA sampled on the q2->q3 tick.
- States: IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP.
  - START: SCL=1 throughout; sda_oe=0 in q0,q1, 1 in q2,q3 (SDA falls with SCL high).
  - ADDR: 8 bits, MSB first: cmd_addr[6:0] then cmd_rw. sda_oe = ~bit.
  - ADDR_ACK: sda_oe=0; sampled sda_in=1 -> ack_err=1, go STOP. Otherwise WDATA (rw=0) or RDATA (rw=1).
  - WDATA: 8 bits of cmd_wdata, MSB first.
  - WACK: sda_oe=0; sda_in=1 sets ack_err. Always go STOP.
  - RDATA: sda_oe=0; shift sda_in MSB first.
  - RNACK: sda_oe=0 (master NACK). rd_data updated and rd_valid pulsed once at end of RNACK. Then STOP.
  - STOP: q0 SCL=0, sda_oe=1; q1,q2 SCL=1, sda_oe=1; q3 SCL=1, sda_oe=0 (SDA rises with SCL high). Then IDLE.
- busy deasserts in the cycle IDLE is entered; a new command may be accepted that same cycle.
- Durations:
  - Full transaction: 80 quarters = 80*CLK_DIV clks (2000 at default).
  - Address NACK: 44 quarters.
- ack_err clears on acceptance of the next command.
- rd_valid never asserts on write commands or after an address NACK.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- Defined: in q2/q3 the divider holds while scl_in=0 (slave stretching). No tick, no sample, no state advance until scl_in=1.
- Undefined: scl_in ignored; timing purely from the divider.

Test Plan:
- Write: addr 0x50, wdata 0xA5, bench ACKs both -> sda_oe bit pattern matches START, 0xA0, ACK, 0xA5, ACK, STOP. ack_err=0. busy high exactly 2000 clks.
- Read: addr 0x50, rw=1, bench drives 0x3C -> rd_valid single pulse, rd_data=0x3C, master SDA released in RNACK slot.
- Address NACK: bench leaves SDA high -> ack_err=1, no data phase, STOP follows, busy duration 44*CLK_DIV.
- Reset mid-ADDR (bit 3) -> next clk SCL=1, sda_oe=0, busy=0, cmd_ready=1. Next command runs normally.
- Back-to-back: cmd_valid held high across two commands -> second accepted in the IDLE cycle, no extra idle quarters.
- I2C_CLOCK_STRETCH_EN: hold scl_in=0 for 100 clks during WDATA bit 2 -> transaction lengthens by exactly 100 clks, data intact.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address + R/W, one data byte with ACK handling, STOP.
// Define I2C_CLOCK_STRETCH_EN to let a slave stretch SCL (divider holds in q2/q3 while scl_in=0).
`timescale 1ns/1ps
module i2c_master_ctrl #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       ack_err,
    output logic       busy,
    output logic       SCL,
    output logic       sda_oe,
    input  logic       sda_in,
    input  logic       scl_in
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic        samp_q, samp_d;
    logic        busy_q, busy_d;
    logic        ack_err_q, ack_err_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;
    logic        hold, tick, sample, phase_end;

`ifdef I2C_CLOCK_STRETCH_EN
    assign hold = (state_q != IDLE) && qtr_q[1] && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold = 1'b0;
`endif

    assign tick      = (state_q != IDLE) && (div_q == DIV_LAST) && !hold;
    assign sample    = tick && (qtr_q == 2'd2);
    assign phase_end = tick && (qtr_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rx_d       = rx_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        samp_d     = samp_q;
        busy_d     = busy_q;
        ack_err_d  = ack_err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (state_q == IDLE) begin
            div_d = '0;
            qtr_d = '0;
            if (cmd_valid && cmd_ready) begin
                state_d   = START;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                rw_d      = cmd_rw;
                sh_d      = {cmd_addr, cmd_rw};
                wdata_d   = cmd_wdata;
                bit_d     = '0;
            end
        end else begin
            if (!hold) div_d = (div_q == DIV_LAST) ? '0 : div_q + 16'd1;
            if (tick) qtr_d = qtr_q + 2'd1;
            if (sample) begin
                samp_d = sda_in;
                if (state_q == RDATA) rx_d = {rx_q[6:0], sda_in};
                if ((state_q == ADDR_ACK || state_q == WACK) && sda_in) ack_err_d = 1'b1;
            end
            // Phase transitions happen on the q3 -> q0 tick, so SDA only moves with SCL low
            if (phase_end) begin
                case (state_q)
                    START: begin
                        state_d = ADDR;
                        bit_d   = '0;
                    end
                    ADDR, WDATA: begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ADDR_ACK : WACK;
                    end
                    ADDR_ACK: begin
                        bit_d = '0;
                        if (samp_q) begin
                            state_d = STOP;
                        end else if (rw_q) begin
                            state_d = RDATA;
                        end else begin
                            state_d = WDATA;
                            sh_d    = wdata_q;
                        end
                    end
                    WACK: state_d = STOP;
                    RDATA: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = RNACK;
                    end
                    RNACK: begin
                        state_d    = STOP;
                        rd_data_d  = rx_q;
                        rd_valid_d = 1'b1;
                    end
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Bus pins are decoded from the next state so they land registered with it
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            IDLE:  scl_d = 1'b1;
            START: sda_oe_d = qtr_d[1];
            ADDR, WDATA: begin
                scl_d    = qtr_d[1];
                sda_oe_d = ~sh_d[7];
            end
            STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = (qtr_d != 2'd3);
            end
            default: scl_d = qtr_d[1];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            rw_q       <= 1'b0;
            samp_q     <= 1'b0;
            busy_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            rw_q       <= rw_d;
            samp_q     <= samp_d;
            busy_q     <= busy_d;
            ack_err_q  <= ack_err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q    <= sh_d;
        rx_q    <= rx_d;
        wdata_q <= wdata_d;
    end

    assign cmd_ready = ~busy_q;
    assign busy      = busy_q;
    assign ack_err   = ack_err_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign SCL       = scl_q;
    assign sda_oe    = sda_oe_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bus-level slave decodes SCL/SDA, a scoreboard checks each transaction.
// Define I2C_CLOCK_STRETCH_EN to add the clock-stretch scenario.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 4;

    logic       clk, rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata, rd_data;
    logic       rd_valid, ack_err, busy, SCL, sda_oe, sda_in, scl_in;
    logic       slv_pull, stretch;

    assign sda_in = ~sda_oe & ~slv_pull;
    assign scl_in = SCL & ~stretch;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_data(rd_data), .rd_valid(rd_valid), .ack_err(ack_err), .busy(busy),
        .SCL(SCL), .sda_oe(sda_oe), .sda_in(sda_in), .scl_in(scl_in)
    );

    typedef struct {
        bit         aborted;
        logic [7:0] abyte;
        logic [7:0] dbyte;
        bit         chk_data;
        logic       ack1;
        logic       ack2;
        int         nrise;
        int         cycles;
        int         rdv_cnt;
        logic [7:0] rdat;
        logic       aerr;
    } exp_t;

    typedef struct packed {
        logic       ack_a;
        logic       ack_d;
        logic       rw;
        logic [7:0] rbyte;
    } cfg_t;

    exp_t       exp_q[$];
    cfg_t       cfg_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] model_rd = 8'h00;

    // Slave-side observations of the current transaction
    logic [7:0] s_abyte, s_dbyte;
    logic       s_ack1, s_ack2, s_start, s_stop;
    int         s_nrise;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: acts on SCL/SDA edges seen at the falling clk edge
    initial begin
        cfg_t cur;
        logic scl_p, line_p, scl_n, line_n;
        int   bitcnt, idx;
        scl_p = 1'b1; line_p = 1'b1; bitcnt = 0;
        slv_pull = 1'b0;
        cur = '{ack_a: 1'b1, ack_d: 1'b1, rw: 1'b0, rbyte: 8'h00};
        s_abyte = 0; s_dbyte = 0; s_ack1 = 1; s_ack2 = 1; s_start = 0; s_stop = 0; s_nrise = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                slv_pull = 1'b0;
                scl_p    = SCL;
                line_p   = ~sda_oe;
            end else begin
                scl_n  = SCL;
                line_n = ~sda_oe & ~slv_pull;
                if (scl_p && scl_n && line_p && !line_n) begin
                    s_start = 1; s_stop = 0; bitcnt = 0; s_nrise = 0;
                    s_abyte = 0; s_dbyte = 0; s_ack1 = 1; s_ack2 = 1;
                    if (cfg_q.size() > 0) cur = cfg_q.pop_front();
                end else if (scl_p && scl_n && !line_p && line_n) begin
                    s_stop = 1;
                end else if (!scl_p && scl_n) begin
                    bitcnt++;
                    s_nrise = bitcnt;
                    if (bitcnt <= 8) s_abyte = {s_abyte[6:0], line_n};
                    else if (bitcnt == 9) s_ack1 = line_n;
                    else if (bitcnt <= 17) s_dbyte = {s_dbyte[6:0], line_n};
                    else if (bitcnt == 18) s_ack2 = line_n;
                end else if (scl_p && !scl_n) begin
                    slv_pull = 1'b0;
                    if (bitcnt == 8) begin
                        slv_pull = cur.ack_a;
                    end else if (bitcnt >= 9 && bitcnt <= 16 && cur.rw && cur.ack_a) begin
                        idx = 16 - bitcnt;
                        slv_pull = ~cur.rbyte[idx];
                    end else if (bitcnt == 17 && !cur.rw && cur.ack_a) begin
                        slv_pull = cur.ack_d;
                    end
                end
                scl_p  = scl_n;
                line_p = ~sda_oe & ~slv_pull;
            end
        end
    end

    // Scoreboard monitor: one expected record per busy window
    initial begin
        exp_t       e;
        bit         bprev;
        int         bcnt, rdv_cnt;
        logic [7:0] rdv_data;
        bprev = 0; bcnt = 0; rdv_cnt = 0; rdv_data = 8'h00;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (rd_valid === 1'b1) begin
                rdv_cnt++;
                rdv_data = rd_data;
            end
            if (bprev && busy !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_end", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("end_scl", SCL, 1);
                    chk("end_sda_oe", sda_oe, 0);
                    chk("end_cmd_ready", cmd_ready, 1);
                    chk("rd_data", rd_data, e.rdat);
                    chk("rd_valid_cnt", rdv_cnt, e.rdv_cnt);
                    if (e.aborted) begin
                        chk("rst_ack_err", ack_err, 0);
                        chk("rst_rd_valid", rd_valid, 0);
                    end else begin
                        chk("busy_cycles", bcnt, e.cycles);
                        chk("ack_err", ack_err, e.aerr);
                        chk("start_seen", s_start, 1);
                        chk("stop_seen", s_stop, 1);
                        chk("addr_byte", s_abyte, e.abyte);
                        chk("addr_ack", s_ack1, e.ack1);
                        chk("scl_rises", s_nrise, e.nrise);
                        if (e.rdv_cnt == 1) chk("rd_valid_data", rdv_data, e.rdat);
                        if (e.chk_data) begin
                            chk("data_byte", s_dbyte, e.dbyte);
                            chk("data_ack", s_ack2, e.ack2);
                        end
                    end
                end
                bcnt = 0;
                rdv_cnt = 0;
            end
            bprev = (busy === 1'b1);
        end
    end

    // Reference model: expected outcome derived from the protocol rules, then the command is issued
    task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                        input logic ack_a, input logic ack_d, input logic [7:0] rb,
                        input bit keep, input bit abort, input int extra, output int acc);
        exp_t e;
        cfg_t c;
        int   n;
        e.aborted  = abort;
        e.abyte    = {addr, rw};
        e.ack1     = ~ack_a;
        e.dbyte    = rw ? rb : wd;
        e.chk_data = 0;
        e.ack2     = 1'b1;
        e.nrise    = 10;
        e.cycles   = 44 * CLK_DIV + extra;
        e.rdv_cnt  = 0;
        e.aerr     = 1'b1;
        if (abort) begin
            model_rd = 8'h00;
        end else if (ack_a) begin
            e.chk_data = 1;
            e.ack2     = rw ? 1'b1 : ~ack_d;
            e.nrise    = 19;
            e.cycles   = 80 * CLK_DIV + extra;
            e.rdv_cnt  = rw ? 1 : 0;
            e.aerr     = ~rw & ~ack_d;
            if (rw) model_rd = rb;
        end
        e.rdat = model_rd;
        exp_q.push_back(e);
        c = '{ack_a: ack_a, ack_d: ack_d, rw: rw, rbyte: rb};
        cfg_q.push_back(c);

        @(negedge clk);
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep) cmd_valid = 1'b0;
    endtask

    initial begin
        int          acc, t1, t2, gap, w;
        logic [31:0] r;
        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        stretch = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_scl", SCL, 1);
        chk("reset_sda_oe", sda_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_ack_err", ack_err, 0);
        chk("reset_rd_data", rd_data, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 0, 0, 0, acc);
        send(1'b1, 7'h50, 8'h00, 1'b1, 1'b1, 8'h3C, 0, 0, 0, acc);
        send(1'b0, 7'h50, 8'h77, 1'b0, 1'b1, 8'h00, 0, 0, 0, acc);
        send(1'b0, 7'h51, 8'h81, 1'b1, 1'b0, 8'h00, 0, 0, 0, acc);

        // Abort in the middle of address bit 3 (quarter 17)
        send(1'b0, 7'h2A, 8'h96, 1'b1, 1'b1, 8'h00, 0, 1, 0, acc);
        repeat (17 * CLK_DIV + 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b0, 7'h2A, 8'h96, 1'b1, 1'b1, 8'h00, 0, 0, 0, acc);

        send(1'b0, 7'h11, 8'h5A, 1'b1, 1'b1, 8'h00, 1, 0, 0, t1);
        send(1'b1, 7'h22, 8'h00, 1'b1, 1'b1, 8'hC3, 0, 0, 0, t2);
        chk("b2b_accept_gap", t2 - t1, 80 * CLK_DIV + 1);

`ifdef I2C_CLOCK_STRETCH_EN
        send(1'b0, 7'h33, 8'h6E, 1'b1, 1'b1, 8'h00, 0, 0, 100, acc);
        repeat (50 * CLK_DIV + 1) @(posedge clk);
        @(negedge clk);
        stretch = 1'b1;
        repeat (100) @(negedge clk);
        stretch = 1'b0;
`endif

        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            send(r[0], r[7:1], r[15:8], (r[18:16] != 3'd0), (r[21:19] != 3'd0), r[29:22],
                 0, 0, 0, acc);
            gap = $urandom_range(0, 4);
            repeat (gap) @(negedge clk);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 400 * CLK_DIV) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drain", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
